// File: rtl/andn_param_if.sv
// Beat and result handshake bundle for andn_param.
// The slave side is the reduction block; the master side is the producer/consumer.
interface andn_param_if #(
   parameter int WIDTH    = 3,
   parameter int CHANNELS = 2
);
   logic [1:0]                mode;
   logic                      in_valid;
   logic                      in_ready;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [CHANNELS-1:0]       out_data;

   modport master (
      output mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/andn_param.sv
// Per-channel AND/OR/XOR/NAND reduction of accepted beats into a DEPTH-entry result FIFO.
// Define ANDN_PARAM_STATS_EN to add per-channel ones counters (cnt_clr / ones_cnt).
module andn_param #(
   parameter int WIDTH    = 3,
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 16
) (
   input  logic clk,
   input  logic reset_n,
   andn_param_if.slave bus
`ifdef ANDN_PARAM_STATS_EN
   ,
   input  logic                      cnt_clr,
   output logic [CHANNELS*CNT_W-1:0] ones_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [CHANNELS-1:0] mem_q [DEPTH];
   logic [CHANNELS-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]    occ_q, occ_d;
   logic [CHANNELS-1:0] out_data_q, out_data_d;
   logic [CHANNELS-1:0] beat_res;
   logic [WIDTH-1:0]    grp;
   logic                push;
   logic                pop;

   always_comb begin
      beat_res = '0;
      grp      = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         grp = bus.in_data[c*WIDTH +: WIDTH];
         case (bus.mode)
            2'b00:   beat_res[c] = &grp;
            2'b01:   beat_res[c] = |grp;
            2'b10:   beat_res[c] = ^grp;
            default: beat_res[c] = ~&grp;
         endcase
      end
   end

   // in_ready depends only on occupancy (and reset), so a pop at full cannot free a slot the same cycle
   assign bus.in_ready  = reset_n && (occ_q != OCC_FULL);
   assign bus.out_valid = (occ_q != '0);
   assign bus.out_data  = out_data_q;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = reset_n && bus.out_valid && bus.out_ready;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      out_data_d = out_data_q;

      if (push) begin
         mem_d[wr_ptr_q] = beat_res;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase

      // Head register: follows the new head, or keeps the last shown value when empty
      if (occ_d != '0) begin
         out_data_d = mem_d[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         out_data_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         out_data_q <= out_data_d;
      end
   end

`ifdef ANDN_PARAM_STATS_EN
   logic [CHANNELS*CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (pop) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (out_data_q[c] && (cnt_q[c*CNT_W +: CNT_W] != '1)) begin
               cnt_d[c*CNT_W +: CNT_W] = cnt_q[c*CNT_W +: CNT_W] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ones_cnt = cnt_q;
`else
   // CNT_W only sizes the counters; kept so both builds share one parameter list
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

endmodule

// File: tb/tb_andn_param.sv
// Directed bench for andn_param with a queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_andn_param;
   localparam int WIDTH    = 3;
   localparam int CHANNELS = 2;
   localparam int DEPTH    = 4;
   localparam int CNT_W    = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   andn_param_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

`ifdef ANDN_PARAM_STATS_EN
   logic                      cnt_clr = 1'b0;
   logic [CHANNELS*CNT_W-1:0] ones_cnt;
   int                        m_cnt [CHANNELS];
`endif

   andn_param #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef ANDN_PARAM_STATS_EN
      ,
      .cnt_clr (cnt_clr),
      .ones_cnt(ones_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reduction rule from bit counts: AND = all ones, OR = any one, XOR = odd count, NAND = not all ones
   function automatic logic [CHANNELS-1:0] model_beat(input logic [CHANNELS*WIDTH-1:0] d,
                                                     input logic [1:0] m);
      logic [CHANNELS-1:0] r;
      int n;
      r = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         n = $countones(d[c*WIDTH +: WIDTH]);
         case (m)
            2'd0:    r[c] = (n == WIDTH);
            2'd1:    r[c] = (n != 0);
            2'd2:    r[c] = (n % 2 == 1);
            default: r[c] = (n != WIDTH);
         endcase
      end
      return r;
   endfunction

   logic [CHANNELS-1:0] mq [$];
   logic [CHANNELS-1:0] m_hold;

   always @(posedge clk) begin
      bit acc;
      bit pp;
      if (!reset_n) begin
         mq.delete();
         m_hold = '0;
`ifdef ANDN_PARAM_STATS_EN
         foreach (m_cnt[c]) m_cnt[c] = 0;
`endif
      end else begin
         acc = bus.in_valid && (mq.size() < DEPTH);
         pp  = bus.out_ready && (mq.size() > 0);
`ifdef ANDN_PARAM_STATS_EN
         if (cnt_clr) begin
            foreach (m_cnt[c]) m_cnt[c] = 0;
         end else if (pp) begin
            foreach (m_cnt[c])
               if (mq[0][c] && m_cnt[c] < (1 << CNT_W) - 1) m_cnt[c]++;
         end
`endif
         if (pp) m_hold = mq.pop_front();
         if (acc) mq.push_back(model_beat(bus.in_data, bus.mode));
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready", 32'(bus.in_ready), 32'(reset_n && (mq.size() < DEPTH)));
         chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) chk("out_data", 32'(bus.out_data), 32'(mq[0]));
         else                chk("out_data_hold", 32'(bus.out_data), 32'(m_hold));
`ifdef ANDN_PARAM_STATS_EN
         for (int c = 0; c < CHANNELS; c++)
            chk("ones_cnt", 32'(ones_cnt[c*CNT_W +: CNT_W]), 32'(m_cnt[c]));
`endif
      end
   end

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   logic [1:0]          sweep_exp [4] = '{2'b10, 2'b11, 2'b10, 2'b01};
   logic [5:0]          fill_data [5] = '{6'b000_001, 6'b100_000, 6'b000_000, 6'b010_100, 6'b111_111};
   logic [1:0]          fill_exp  [4] = '{2'b01, 2'b10, 2'b00, 2'b11};

   initial begin
      int  idx;
      int  acc_cnt;
      int  sent;
      int  got;
      int  cyc;
      bit  a;
      bit  p;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.mode      = 2'b00;
      bus.out_ready = 1'b0;

      // reset
      reset_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 cmp_en = 1'b1;
      @(negedge clk);
      chk("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
      #1 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      #1;

      // mode sweep
      bus.out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 6'b111_011;
         bus.mode     = 2'(m);
         @(posedge clk);
         @(negedge clk);
         chk("sweep_data", 32'(bus.out_data), 32'(sweep_exp[m]));
         chk("sweep_valid", 32'(bus.out_valid), 32'd1);
         #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("sweep_empty", 32'(bus.out_valid), 32'd0);
      chk("sweep_hold", 32'(bus.out_data), 32'd1);
      #1;

      // fill and backpressure
      bus.out_ready = 1'b0;
      bus.mode      = 2'b01;
      idx = 0;
      acc_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = fill_data[idx];
         a = bus.in_ready;
         cycle();
         if (a) begin
            acc_cnt++;
            idx++;
         end
      end
      chk("fill_accepted", 32'(acc_cnt), 32'd4);
      chk("fill_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("drain_data", 32'(bus.out_data), 32'(fill_exp[k]));
         @(posedge clk);
         @(negedge clk);
         if (k == 0) chk("drain_ready", 32'(bus.in_ready), 32'd1);
         #1;
      end

      // full with simultaneous pop: no push that cycle
      bus.out_ready = 1'b0;
      bus.mode      = 2'b10;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.in_data = 6'(k * 11 + 3);
         cycle();
      end
      bus.in_data   = 6'b100_110;
      bus.out_ready = 1'b1;
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("pop_full_ready", 32'(bus.in_ready), 32'd1);
      #1;
      bus.out_ready = 1'b0;
      cycle();
      chk("refill_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) chk("late_beat", 32'(bus.out_data), 32'd2);
         cycle();
      end

      // wrap-around stream with random backpressure
      sent = 0;
      got  = 0;
      cyc  = 0;
      bus.in_data = 6'($urandom);
      bus.mode    = 2'($urandom);
      while ((sent < 10 || got < 10) && cyc < 200) begin
         bus.in_valid  = (sent < 10);
         bus.out_ready = 1'($urandom_range(0, 1));
         a = bus.in_valid && bus.in_ready;
         p = bus.out_valid && bus.out_ready;
         cycle();
         if (a) begin
            sent++;
            bus.in_data = 6'($urandom);
            bus.mode    = 2'($urandom);
         end
         if (p) got++;
         cyc++;
      end
      chk("wrap_sent", 32'(sent), 32'd10);
      chk("wrap_got", 32'(got), 32'd10);
      bus.in_valid = 1'b0;

      // reset mid-operation
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.mode      = 2'b01;
      for (int k = 0; k < 3; k++) begin
         bus.in_data = 6'b000_111;
         cycle();
      end
      bus.in_valid = 1'b0;
      reset_n      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("midrst_valid", 32'(bus.out_valid), 32'd0);
      #1 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("postrst_valid", 32'(bus.out_valid), 32'd0);
      chk("postrst_data", 32'(bus.out_data), 32'd0);
      chk("postrst_ready", 32'(bus.in_ready), 32'd1);
      #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.mode      = 2'b00;
      bus.in_data   = 6'b111_111;
      @(posedge clk);
      @(negedge clk);
      chk("postrst_new", 32'(bus.out_data), 32'd3);
      #1;
      bus.in_valid = 1'b0;
      cycle();

`ifdef ANDN_PARAM_STATS_EN
      // statistics: saturation and clear priority
      bus.out_ready = 1'b0;
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      chk("stats_clr", 32'(ones_cnt), 32'd0);
      bus.out_ready = 1'b1;
      bus.mode      = 2'b01;
      bus.in_data   = 6'b000_001;
      bus.in_valid  = 1'b1;
      for (int k = 0; k < 5; k++) cycle();
      bus.in_valid = 1'b0;
      cycle();
      chk("stats_sat_ch0", 32'(ones_cnt[CNT_W-1:0]), 32'd3);
      chk("stats_ch1", 32'(ones_cnt[2*CNT_W-1:CNT_W]), 32'd0);
      bus.in_valid = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      cnt_clr = 1'b1;
      chk("stats_pop_pending", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("stats_clr_prio", 32'(ones_cnt), 32'd0);
      #1 cnt_clr = 1'b0;
      cycle();
`endif

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end
endmodule

// File: doc/andn_param.md
# andn_param

Parametrised successor to the fixed three-input AND cell. Reduces CHANNELS independent groups of WIDTH input bits each, using a selectable AND/OR/XOR/NAND operator. Input beats are accepted through a valid/ready handshake, and results are buffered in a DEPTH-entry FIFO so the consumer can apply backpressure. An optional per-channel statistics block counts the ones delivered on each channel.

## Interface
- WIDTH, 3, input bits per channel (≥2)
- CHANNELS, 2, independent reduction channels (≥1)
- DEPTH, 4, result FIFO entries (power of two, ≥2)
- CNT_W, 16, statistics counter width (only used with ANDN_PARAM_STATS_EN)
- clk  input  1  single clock, rising edge
- reset_n  input  1  synchronous active-low reset
- mode  input  2  operator, sampled with each accepted beat: 00 AND, 01 OR, 10 XOR, 11 NAND
- in_valid  input  1  in_data/mode valid
- in_ready  output  1  block can accept a beat
- in_data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer takes head
- out_data  output  CHANNELS  bit c = reduced result of channel c
- cnt_clr  input  1  clear statistics (present only with ANDN_PARAM_STATS_EN)
- ones_cnt  output  CHANNELS*CNT_W  per-channel ones count (present only with ANDN_PARAM_STATS_EN)

## Operation
- Accept: a beat is accepted when in_valid && in_ready.
- On acceptance, each channel is reduced with the sampled mode. The CHANNELS-bit result is written to the FIFO tail.
- Mode applies per beat. Changing mode between beats never alters results already in the FIFO.
- Pop: the head is removed when out_valid && out_ready. out_data always shows the head entry.
- in_ready = (occupancy < DEPTH). It is registered/derived from occupancy only, with no combinational path from out_ready.
- Full: in_ready is low. A pop in the same cycle does not permit a push. in_ready rises the cycle after the pop.
- Empty: out_valid is low and out_data holds its last value. A push into an empty FIFO is visible next cycle.
- Simultaneous push and pop when not full and not empty: occupancy is unchanged and the pointers both advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- in_valid low while in_ready is high is legal. No beat is accepted.
- A beat offered while in_ready is low must be held by the source. The block ignores it.

## Timing
- Latency: a beat accepted at edge N gives out_valid=1 with its result after edge N, so it is poppable at edge N+1.
- Throughput: 1 beat/cycle when out_ready is held high.
- Reset (reset_n low at a rising edge): out_valid=0, out_data=0, in_ready=1 (from the cycle after the reset edge), pointers=0, occupancy=0, ones_cnt=0.
- Reset mid-operation discards all FIFO contents. No pop occurs during a reset cycle.
- in_ready is low while reset_n is low.

## Configuration
- ANDN_PARAM_STATS_EN defined:
  - Adds cnt_clr and ones_cnt.
  - On each pop, ones_cnt[c] increments if out_data[c]=1.
  - Counters saturate at 2^CNT_W−1.
  - cnt_clr clears counters to 0 and has priority over a same-cycle pop increment.
- Not defined: no counters, no cnt_clr/ones_cnt ports. FIFO behaviour is identical.

## Test plan
All scenarios use WIDTH=3, CHANNELS=2, DEPTH=4.
- Mode sweep: in_data=6'b111_011, modes 00/01/10/11, out_ready=1 → out_data = 2'b10, 2'b11, 2'b10, 2'b01, each one cycle after its beat.
- Fill/backpressure: out_ready=0, offer 6 beats → exactly 4 accepted, in_ready=0 after the 4th. Drain with out_ready=1 → 4 results in order, in_ready=1 the cycle after the first pop.
- Full + pop same cycle: FIFO full, out_ready=1 with in_valid=1 → no push that cycle, occupancy goes 4→3, the beat is accepted the next cycle.
- Wrap-around: 10 beats streamed at 1/cycle with random out_ready → in-order delivery, no loss or duplication, pointers wrap twice.
- Reset mid-operation: 3 entries queued, reset_n=0 for one edge → out_valid=0, in_ready=1 afterwards, old entries are never seen.
- Stats (ANDN_PARAM_STATS_EN, CNT_W=2): pop 5 results with channel-0 result=1 → ones_cnt[0] saturates at 3. cnt_clr asserted with a pop → 0.
